difftest_comparator: RTL and testbench

- Consumer stage downstream of the DUT data generator and the matching REF data generator.
- Pops one 128-bit {reg, pc} entry from the DUT FIFO and one from the REF FIFO, then compares the pair.
- Drives a status flag back to the DUT-side producer. It also raises irq_dut_empty to halt the DUT on a mismatch, on a timeout, or on each step in single-step mode.
- Captures the first mismatching pair for software readout.

---
 rtl/difftest_pkg.sv | 26 ++
 rtl/difftest_entry_cmp.sv | 20 ++
 rtl/difftest_comparator.sv | 202 ++++++++++++++++++++
 tb/tb_difftest_comparator.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/difftest_pkg.sv
// Shared definitions for the difftest comparator: FSM encoding, entry field
// positions and mismatch kind bit positions.
package difftest_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitData = 3'd1,
        StPop      = 3'd2,
        StLatch    = 3'd3,
        StCmp      = 3'd4,
        StHalt     = 3'd5,
        StStep     = 3'd6
    } state_t;

    // Entry layout: {reg, pc}
    localparam int unsigned PC_LSB  = 0;
    localparam int unsigned PC_MSB  = 63;
    localparam int unsigned REG_LSB = 64;
    localparam int unsigned REG_MSB = 127;

    // mismatch_kind bit positions
    localparam int unsigned KIND_W   = 2;
    localparam int unsigned KIND_PC  = 0;
    localparam int unsigned KIND_REG = 1;

endpackage

// File: rtl/difftest_entry_cmp.sv
// Combinational compare of one DUT entry against one REF entry.
// kind == 0 means the pair matches.
module difftest_entry_cmp
    import difftest_pkg::*;
#(
    parameter int unsigned DATA_W = 128
) (
    input  logic [DATA_W-1:0] dut_entry,
    input  logic [DATA_W-1:0] ref_entry,
    output logic [KIND_W-1:0] kind
);

    // Per-field inequality flags
    always_comb begin
        kind           = '0;
        kind[KIND_PC]  = (dut_entry[PC_MSB:PC_LSB] != ref_entry[PC_MSB:PC_LSB]);
        kind[KIND_REG] = (dut_entry[REG_MSB:REG_LSB] != ref_entry[REG_MSB:REG_LSB]);
    end

endmodule

// File: rtl/difftest_comparator.sv
// Pops paired {reg, pc} entries from the DUT and REF FIFOs, compares them,
// halts the DUT producer on mismatch/timeout/step and captures the first
// mismatching pair for software readout.
module difftest_comparator
    import difftest_pkg::*;
#(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned COUNT_W = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               dut_fifo_empty,
    input  logic [DATA_W-1:0]  dut_fifo_rd_data,
    output logic               dut_fifo_rd_en,
    input  logic               ref_fifo_empty,
    input  logic [DATA_W-1:0]  ref_fifo_rd_data,
    output logic               ref_fifo_rd_en,
    input  logic               enable,
    input  logic               step_mode,
    input  logic               step_req,
    input  logic               clear,
    output logic               irq_dut_empty,
    output logic               right,
    output logic [KIND_W-1:0]  mismatch_kind,
    output logic               timeout,
    output logic [DATA_W-1:0]  mis_dut_data,
    output logic [DATA_W-1:0]  mis_ref_data,
    output logic [COUNT_W-1:0] compare_count,
    output logic [2:0]         out_state
);

    localparam int unsigned       TCNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [DATA_W-1:0]   dut_q, ref_q;
    logic [DATA_W-1:0]   mis_dut_q, mis_dut_d;
    logic [DATA_W-1:0]   mis_ref_q, mis_ref_d;
    logic [KIND_W-1:0]   kind_q, kind_d;
    logic [KIND_W-1:0]   cmp_kind;
    logic                irq_q, irq_d;
    logic                timeout_q, timeout_d;
    logic                mis_latched_q, mis_latched_d;
    logic                right_q, right_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                pop;

    difftest_entry_cmp #(
        .DATA_W (DATA_W)
    ) u_entry_cmp (
        .dut_entry (dut_q),
        .ref_entry (ref_q),
        .kind      (cmp_kind)
    );

    // Both strobes come from the same registered state, so they can never split
    assign pop            = (state_q == StPop);
    assign dut_fifo_rd_en = pop;
    assign ref_fifo_rd_en = pop;

    // Next-state, timeout tracking, compare result handling and halt release
    always_comb begin
        state_d       = state_q;
        tcnt_d        = tcnt_q;
        irq_d         = irq_q;
        timeout_d     = timeout_q;
        kind_d        = kind_q;
        mis_latched_d = mis_latched_q;
        mis_dut_d     = mis_dut_q;
        mis_ref_d     = mis_ref_q;
        count_d       = count_q;

        unique case (state_q)
            StIdle: begin
                tcnt_d = '0;
                if (enable) begin
                    state_d = StWaitData;
                end
            end
            StWaitData: begin
                if (!enable) begin
                    tcnt_d  = '0;
                    state_d = StIdle;
                end else if (!dut_fifo_empty && !ref_fifo_empty) begin
                    tcnt_d  = '0;
                    state_d = StPop;
                end else if (dut_fifo_empty != ref_fifo_empty) begin
                    // One side has data while the other stays dry
                    if (tcnt_q == TCNT_MAX) begin
                        tcnt_d    = '0;
                        timeout_d = 1'b1;
                        irq_d     = 1'b1;
                        state_d   = StHalt;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end else begin
                    tcnt_d = '0;
                end
            end
            // Enable is ignored here so a popped pair is always compared
            StPop: begin
                state_d = StLatch;
            end
            StLatch: begin
                state_d = StCmp;
            end
            StCmp: begin
                if (cmp_kind == '0) begin
                    if (count_q != '1) begin
                        count_d = count_q + 1'b1;
                    end
                    if (step_mode) begin
                        irq_d   = 1'b1;
                        state_d = StStep;
                    end else begin
                        state_d = enable ? StWaitData : StIdle;
                    end
                end else begin
                    mis_dut_d     = dut_q;
                    mis_ref_d     = ref_q;
                    kind_d        = cmp_kind;
                    mis_latched_d = 1'b1;
                    irq_d         = 1'b1;
                    state_d       = StHalt;
                end
            end
            StHalt: begin
                if (clear) begin
                    irq_d         = 1'b0;
                    timeout_d     = 1'b0;
                    kind_d        = '0;
                    mis_latched_d = 1'b0;
                    state_d       = enable ? StWaitData : StIdle;
                end
            end
            StStep: begin
                // Dropping step_mode releases the halt just like step_req
                if (step_req || !step_mode) begin
                    irq_d   = 1'b0;
                    state_d = StWaitData;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // right tracks enable, but stays low while a mismatch is latched
    assign right_d = enable & ~mis_latched_d;

    // Control and status registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= StIdle;
            tcnt_q        <= '0;
            irq_q         <= 1'b0;
            timeout_q     <= 1'b0;
            kind_q        <= '0;
            mis_latched_q <= 1'b0;
            right_q       <= 1'b0;
            count_q       <= '0;
            mis_dut_q     <= '0;
            mis_ref_q     <= '0;
        end else begin
            state_q       <= state_d;
            tcnt_q        <= tcnt_d;
            irq_q         <= irq_d;
            timeout_q     <= timeout_d;
            kind_q        <= kind_d;
            mis_latched_q <= mis_latched_d;
            right_q       <= right_d;
            count_q       <= count_d;
            mis_dut_q     <= mis_dut_d;
            mis_ref_q     <= mis_ref_d;
        end
    end

    // Capture the popped pair; FIFO read data is valid in the LATCH cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dut_q <= '0;
            ref_q <= '0;
        end else if (state_q == StLatch) begin
            dut_q <= dut_fifo_rd_data;
            ref_q <= ref_fifo_rd_data;
        end
    end

    assign irq_dut_empty = irq_q;
    assign right         = right_q;
    assign mismatch_kind = kind_q;
    assign timeout       = timeout_q;
    assign mis_dut_data  = mis_dut_q;
    assign mis_ref_data  = mis_ref_q;
    assign compare_count = count_q;
    assign out_state     = state_q;

endmodule

// File: tb/tb_difftest_comparator.sv
// Self-checking bench for difftest_comparator: table of paired entries plus
// directed sequences for halt, clear, timeout, step and mid-pop reset.
module tb_difftest_comparator;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_CMP   = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;
    localparam logic [2:0] S_STEP  = 3'd6;

    logic         clk = 1'b0;
    logic         resetn;
    logic         dut_fifo_empty = 1'b1;
    logic [127:0] dut_fifo_rd_data = '0;
    logic         dut_fifo_rd_en;
    logic         ref_fifo_empty = 1'b1;
    logic [127:0] ref_fifo_rd_data = '0;
    logic         ref_fifo_rd_en;
    logic         enable, step_mode, step_req, clear;
    logic         irq_dut_empty, right, timeout;
    logic [1:0]   mismatch_kind;
    logic [127:0] mis_dut_data, mis_ref_data;
    logic [31:0]  compare_count;
    logic [2:0]   out_state;

    logic [127:0] dq[$];
    logic [127:0] rq[$];

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    logic prev_rd = 1'b0;

    typedef struct {
        logic [63:0] dpc;
        logic [63:0] dreg;
        logic [63:0] rpc;
        logic [63:0] rreg;
        logic [1:0]  kind;
        logic [31:0] count;
        logic        right;
        logic        irq;
        logic [2:0]  state;
    } vec_t;

    vec_t vecs[9];

    difftest_comparator dut (
        .clk              (clk),
        .resetn           (resetn),
        .dut_fifo_empty   (dut_fifo_empty),
        .dut_fifo_rd_data (dut_fifo_rd_data),
        .dut_fifo_rd_en   (dut_fifo_rd_en),
        .ref_fifo_empty   (ref_fifo_empty),
        .ref_fifo_rd_data (ref_fifo_rd_data),
        .ref_fifo_rd_en   (ref_fifo_rd_en),
        .enable           (enable),
        .step_mode        (step_mode),
        .step_req         (step_req),
        .clear            (clear),
        .irq_dut_empty    (irq_dut_empty),
        .right            (right),
        .mismatch_kind    (mismatch_kind),
        .timeout          (timeout),
        .mis_dut_data     (mis_dut_data),
        .mis_ref_data     (mis_ref_data),
        .compare_count    (compare_count),
        .out_state        (out_state)
    );

    always #5 clk = ~clk;

    // FIFO model: read data valid the cycle after rd_en
    always @(posedge clk) begin
        if (dut_fifo_rd_en && dq.size() > 0) dut_fifo_rd_data <= dq.pop_front();
        if (ref_fifo_rd_en && rq.size() > 0) ref_fifo_rd_data <= rq.pop_front();
        dut_fifo_empty <= (dq.size() == 0);
        ref_fifo_empty <= (rq.size() == 0);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; also checks read strobes are paired and one cycle wide
    task automatic tick();
        @(posedge clk);
        #1;
        if (dut_fifo_rd_en || ref_fifo_rd_en) begin
            check("rd_en_paired", dut_fifo_rd_en, ref_fifo_rd_en);
            check("rd_en_width", prev_rd, 1'b0);
            pulses++;
        end
        prev_rd = dut_fifo_rd_en | ref_fifo_rd_en;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output int n);
        logic hit;
        hit = 1'b0;
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (out_state == s) begin
                hit = 1'b1;
                n = i;
                break;
            end
        end
        check("wait_state_reached", hit, 1'b1);
    endtask

    task automatic push_pair(input logic [63:0] dpc, input logic [63:0] dreg,
                             input logic [63:0] rpc, input logic [63:0] rreg);
        dq.push_back({dreg, dpc});
        rq.push_back({rreg, rpc});
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        check("rst_state", out_state, S_IDLE);
        check("rst_count", compare_count, 32'd0);
        check("rst_irq", irq_dut_empty, 1'b0);
        check("rst_right", right, 1'b0);
        resetn = 1'b1;
    endtask

    initial begin
        int n;
        int p0;
        resetn    = 1'b0;
        enable    = 1'b0;
        step_mode = 1'b0;
        step_req  = 1'b0;
        clear     = 1'b0;

        for (int i = 0; i < 8; i++) begin
            vecs[i].dpc   = 64'h8000_0000 + 64'(4 * i);
            vecs[i].rpc   = 64'h8000_0000 + 64'(4 * i);
            vecs[i].dreg  = 64'(i);
            vecs[i].rreg  = 64'(i);
            vecs[i].kind  = 2'b00;
            vecs[i].count = 32'(i + 1);
            vecs[i].right = 1'b1;
            vecs[i].irq   = 1'b0;
            vecs[i].state = S_WAIT;
        end
        vecs[8] = '{dpc: 64'h8000_0020, dreg: 64'h5, rpc: 64'h8000_0020, rreg: 64'h6,
                    kind: 2'b10, count: 32'd8, right: 1'b0, irq: 1'b1, state: S_HALT};

        // Reset state
        tick();
        tick();
        check("reset_state", out_state, S_IDLE);
        check("reset_irq", irq_dut_empty, 1'b0);
        check("reset_right", right, 1'b0);
        check("reset_count", compare_count, 32'd0);
        check("reset_timeout", timeout, 1'b0);
        check("reset_kind", mismatch_kind, 2'b00);
        check("reset_rd_en", {dut_fifo_rd_en, ref_fifo_rd_en}, 2'b00);
        resetn = 1'b1;
        tick();
        check("idle_disabled_right", right, 1'b0);
        enable = 1'b1;
        tick();
        check("enable_state", out_state, S_WAIT);
        check("enable_right", right, 1'b1);

        // Table: 8 matched pairs then a reg mismatch
        for (int i = 0; i < 9; i++) begin
            push_pair(vecs[i].dpc, vecs[i].dreg, vecs[i].rpc, vecs[i].rreg);
            wait_state(S_CMP, 20, n);
            check("latency", n, 4);
            tick();
            check("vec_kind", mismatch_kind, vecs[i].kind);
            check("vec_count", compare_count, vecs[i].count);
            check("vec_right", right, vecs[i].right);
            check("vec_irq", irq_dut_empty, vecs[i].irq);
            check("vec_state", out_state, vecs[i].state);
        end
        check("reg_mis_dut", mis_dut_data[127:64], 64'h5);
        check("reg_mis_ref", mis_ref_data[127:64], 64'h6);

        // step_req has no effect in HALT
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("halt_ignores_step_state", out_state, S_HALT);
        check("halt_ignores_step_irq", irq_dut_empty, 1'b1);

        // clear releases the halt, capture is retained
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_irq", irq_dut_empty, 1'b0);
        check("clear_kind", mismatch_kind, 2'b00);
        check("clear_right", right, 1'b1);
        check("clear_state", out_state, S_WAIT);
        check("clear_keeps_capture", mis_dut_data[127:64], 64'h5);
        push_pair(64'h8000_0100, 64'h9, 64'h8000_0100, 64'h9);
        wait_state(S_CMP, 20, n);
        tick();
        check("resume_count", compare_count, 32'd9);
        check("resume_state", out_state, S_WAIT);

        // PC mismatch on the 4th of a burst
        do_reset();
        tick();
        p0 = pulses;
        for (int i = 0; i < 3; i++)
            push_pair(64'h8000_0000 + 64'(4 * i), 64'(i), 64'h8000_0000 + 64'(4 * i), 64'(i));
        push_pair(64'h8000_000C, 64'h3, 64'h8000_0010, 64'h3);
        push_pair(64'h8000_0014, 64'h4, 64'h8000_0014, 64'h4);
        push_pair(64'h8000_0018, 64'h5, 64'h8000_0018, 64'h5);
        wait_state(S_HALT, 100, n);
        check("pc_mis_kind", mismatch_kind, 2'b01);
        check("pc_mis_right", right, 1'b0);
        check("pc_mis_irq", irq_dut_empty, 1'b1);
        check("pc_mis_dut_pc", mis_dut_data[63:0], 64'h8000_000C);
        check("pc_mis_ref_pc", mis_ref_data[63:0], 64'h8000_0010);
        check("pc_mis_count", compare_count, 32'd3);
        check("pc_mis_pops", pulses - p0, 4);
        for (int i = 0; i < 20; i++) tick();
        check("halt_no_more_pops", pulses - p0, 4);
        check("halt_holds", out_state, S_HALT);

        // Timeout: REF has one entry, DUT stays empty
        do_reset();
        dq.delete();
        rq.delete();
        for (int i = 0; i < 4; i++) tick();
        p0 = pulses;
        rq.push_back({64'h1, 64'h8000_0000});
        wait_state(S_HALT, 1100, n);
        check("timeout_cycles", n, 1025);
        check("timeout_flag", timeout, 1'b1);
        check("timeout_irq", irq_dut_empty, 1'b1);
        check("timeout_right", right, 1'b1);
        check("timeout_no_pop", pulses - p0, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("timeout_clear_flag", timeout, 1'b0);
        check("timeout_clear_irq", irq_dut_empty, 1'b0);
        check("timeout_clear_right", right, 1'b1);

        // Step mode: one compare per release
        do_reset();
        dq.delete();
        rq.delete();
        step_mode = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        p0 = pulses;
        for (int i = 0; i < 3; i++)
            push_pair(64'h8000_0000 + 64'(4 * i), 64'(i), 64'h8000_0000 + 64'(4 * i), 64'(i));
        for (int k = 1; k <= 3; k++) begin
            wait_state(S_STEP, 30, n);
            check("step_count", compare_count, 32'(k));
            check("step_irq", irq_dut_empty, 1'b1);
            for (int i = 0; i < 5; i++) tick();
            check("step_holds", out_state, S_STEP);
            check("step_one_pop", pulses - p0, k);
            if (k == 1) begin
                clear = 1'b1;
                tick();
                clear = 1'b0;
                check("step_ignores_clear", out_state, S_STEP);
                check("step_ignores_clear_irq", irq_dut_empty, 1'b1);
            end
            if (k == 3) begin
                step_mode = 1'b0;
            end else begin
                step_req = 1'b1;
                clear    = (k == 2);
            end
            tick();
            step_req = 1'b0;
            clear    = 1'b0;
            check("step_release_irq", irq_dut_empty, 1'b0);
            check("step_release_state", out_state, S_WAIT);
        end
        check("step_total", compare_count, 32'd3);

        // Reset while a popped pair sits in LATCH
        push_pair(64'h8000_0040, 64'h7, 64'h8000_0040, 64'h7);
        wait_state(S_LATCH, 20, n);
        resetn = 1'b0;
        tick();
        check("latch_rst_state", out_state, S_IDLE);
        check("latch_rst_count", compare_count, 32'd0);
        check("latch_rst_irq", irq_dut_empty, 1'b0);
        check("latch_rst_right", right, 1'b0);
        check("latch_rst_rd_en", {dut_fifo_rd_en, ref_fifo_rd_en}, 2'b00);
        check("latch_rst_mis", mis_dut_data, 128'd0);
        resetn = 1'b1;
        tick();
        push_pair(64'h8000_0044, 64'h8, 64'h8000_0044, 64'h8);
        wait_state(S_CMP, 20, n);
        tick();
        check("post_rst_count", compare_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
